uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit FIFO (`wr_uart` / `w_data` / `tx_full`) between NREQ requesters, such as the ALU result path and status/debug reporters. A requester that wins keeps the FIFO until it has written a complete frame. Frames from different requesters therefore never interleave on the serial line. The block sits between the requester FSMs and the UART TX FIFO write port.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester / TX-FIFO side bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   ack;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic [IDW-1:0]    owner;
  logic              trunc;

  // Environment side: requesters plus the FIFO full flag.
  modport master (
    output req, req_data, req_last, tx_full,
    input  ack, wr_uart, w_data, busy, owner, trunc
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, req_last, tx_full,
    output ack, wr_uart, w_data, busy, owner, trunc
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between NREQ
// requesters; a grant is held for a whole frame (or MAX_FRAME bytes).
module uart_tx_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned MAX_FRAME = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned     CNTW      = $clog2(MAX_FRAME) + 1;
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(MAX_FRAME - 1);
  localparam logic [IDW-1:0]  OWNER_RST = IDW'(NREQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  w_owner_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            r_trunc;
  logic            w_trunc_nxt;

  logic            w_sel_req;
  logic            w_sel_last;
  logic [7:0]      w_sel_data;
  logic            w_found;
  logic [IDW-1:0]  w_rr_idx;
  logic            w_write;
  logic [NREQ-1:0] w_ack;

  // Select the current owner's request, last flag and byte.
  always_comb begin
    w_sel_req  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = 8'h00;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r_owner == IDW'(i)) begin
        w_sel_req  = bus.req[i];
        w_sel_last = bus.req_last[i];
        w_sel_data = bus.req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search starting just after the last owner; the smallest
  // offset is evaluated last so it takes priority.
  always_comb begin
    w_found  = 1'b0;
    w_rr_idx = r_owner;
    for (int k = int'(NREQ); k >= 1; k--) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if (bus.req[j] && (((int'(r_owner) + k) % int'(NREQ)) == j)) begin
          w_found  = 1'b1;
          w_rr_idx = IDW'(j);
        end
      end
    end
  end

  assign w_write = (r_state == S_LOCK) && w_sel_req && !bus.tx_full;

  // One-hot acknowledge to the owner for the byte written this cycle.
  always_comb begin
    w_ack = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_ack[i] = w_write && (r_owner == IDW'(i));
    end
  end

  // Next-state logic: grant, count bytes, release on last/abandon/limit.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_rr_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        if (!w_sel_req) begin
          // Requester walked away mid-frame; keep owner for fairness.
          w_state_nxt = S_IDLE;
        end else if (w_write) begin
          w_cnt_nxt = r_cnt + CNTW'(1);
          if (w_sel_last) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_trunc_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= OWNER_RST;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trunc <= w_trunc_nxt;
    end
  end

  assign bus.wr_uart = w_write;
  assign bus.w_data  = w_sel_data;
  assign bus.ack     = w_ack;
  assign bus.busy    = (r_state == S_LOCK);
  assign bus.owner   = r_owner;
  assign bus.trunc   = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester byte queues drive the DUT,
// expected writes are queued by the stimulus and checked by a monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned MAXF = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_FRAME(MAXF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic [7:0] gap;
  } exp_t;

  exp_t sb[$];

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int last_wr    = 0;
  int trunc_seen = 0;

  logic [8:0]      fmem [NREQ][64];
  int              head [NREQ];
  int              tail [NREQ];
  logic [NREQ-1:0] en;
  logic [NREQ-1:0] ack_s;
  logic            txf;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
  endfunction

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    fmem[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  task automatic exp_wr(input int id, input logic [7:0] d, input int gap);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    e.gap  = 8'(gap);
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      logic act;
      act = en[i] && (head[i] < tail[i]);
      bus.req[i]            = act;
      bus.req_data[8*i +: 8] = act ? fmem[i][head[i]][7:0] : 8'h00;
      bus.req_last[i]       = act && fmem[i][head[i]][8];
    end
    bus.tx_full = txf;
  endtask

  // One clock: requesters advance on the ack seen last cycle, then sample at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (ack_s[i]) head[i]++;
    end
    drive();
    @(negedge clk);
    ack_s = bus.ack;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    ack_s = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 300) begin
      step();
      n++;
    end
    chk(name, 32'(n < 300), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every FIFO write must match the head of the scoreboard.
  always begin : mon
    exp_t e;
    @(negedge clk);
    if (bus.trunc) trunc_seen++;
    if (!reset && bus.wr_uart) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got data 0x%0h from owner %0d expected no write", bus.w_data, bus.owner);
      end else begin
        e = sb.pop_front();
        chk("w_data", 32'(bus.w_data), 32'(e.data));
        chk("ack",    32'(bus.ack),    32'd1 << e.id);
        chk("owner",  32'(bus.owner),  32'(e.id));
        if (e.gap != 8'd0) chk("gap", 32'(cyc - last_wr), 32'(e.gap));
      end
      last_wr = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    en    = '1;
    txf   = 1'b0;
    ack_s = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr",    32'(bus.wr_uart), 32'd0);
    chk("rst_ack",   32'(bus.ack),     32'd0);
    chk("rst_busy",  32'(bus.busy),    32'd0);
    chk("rst_owner", 32'(bus.owner),   32'd3);
    chk("rst_trunc", 32'(bus.trunc),   32'd0);
    chk("rst_wdata", 32'(bus.w_data),  32'd0);
    reset = 1'b0;

    // Basic 3-byte frame from requester 2.
    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h22, 1'b0);
    add_byte(2, 8'h33, 1'b1);
    exp_wr(2, 8'h11, 0);
    exp_wr(2, 8'h22, 1);
    exp_wr(2, 8'h33, 1);
    step();
    chk("t1_idle_wr",   32'(bus.wr_uart), 32'd0);
    chk("t1_idle_busy", 32'(bus.busy),    32'd0);
    step();
    chk("t1_busy",  32'(bus.busy),  32'd1);
    chk("t1_owner", 32'(bus.owner), 32'd2);
    step();
    step();
    step();
    chk("t1_done_busy",  32'(bus.busy),  32'd0);
    chk("t1_owner_kept", 32'(bus.owner), 32'd2);

    // All four requesting single-byte frames: strict rotation 0,1,2,3.
    do_reset();
    chk("t2_owner_rst", 32'(bus.owner), 32'd3);
    for (int r = 0; r < 4; r++) begin
      add_byte(r, 8'(r), 1'b1);
      add_byte(r, 8'(r), 1'b1);
    end
    for (int n = 0; n < 8; n++) exp_wr(n % 4, 8'(n % 4), (n == 0) ? 0 : 2);
    drain("t2_drain");

    // Stall with tx_full while requester 0 waits.
    add_byte(1, 8'hA1, 1'b0);
    add_byte(1, 8'hA2, 1'b0);
    add_byte(1, 8'hA3, 1'b0);
    add_byte(1, 8'hA4, 1'b1);
    exp_wr(1, 8'hA1, 0);
    exp_wr(1, 8'hA2, 6);
    exp_wr(1, 8'hA3, 1);
    exp_wr(1, 8'hA4, 1);
    exp_wr(0, 8'hB0, 2);
    step();
    step();
    chk("t3_owner", 32'(bus.owner), 32'd1);
    add_byte(0, 8'hB0, 1'b1);
    txf = 1'b1;
    repeat (5) begin
      step();
      chk("t3_stall_wr",   32'(bus.wr_uart), 32'd0);
      chk("t3_stall_ack",  32'(bus.ack),     32'd0);
      chk("t3_stall_busy", 32'(bus.busy),    32'd1);
    end
    txf = 1'b0;
    drain("t3_drain");

    // 20 unterminated bytes from requester 3: forced release after 16.
    for (int k = 0; k < 20; k++) begin
      add_byte(3, 8'(8'h40 + k), 1'b0);
      exp_wr(3, 8'(8'h40 + k), (k == 0) ? 0 : ((k == 16) ? 2 : 1));
    end
    step();
    repeat (16) step();
    chk("t4_trunc_early", 32'(bus.trunc), 32'd0);
    chk("t4_busy16",      32'(bus.busy),  32'd1);
    step();
    chk("t4_trunc",     32'(bus.trunc),   32'd1);
    chk("t4_busy_rel",  32'(bus.busy),    32'd0);
    chk("t4_idle_wr",   32'(bus.wr_uart), 32'd0);
    step();
    chk("t4_trunc_clr", 32'(bus.trunc),   32'd0);
    chk("t4_regrant",   32'(bus.busy),    32'd1);
    chk("t4_owner",     32'(bus.owner),   32'd3);
    drain("t4_drain");
    chk("t4_trunc_count", 32'(trunc_seen), 32'd1);

    // Last byte landing exactly on the limit is a normal end of frame.
    for (int k = 0; k < 16; k++) begin
      add_byte(2, 8'(8'h60 + k), k == 15);
      exp_wr(2, 8'(8'h60 + k), (k == 0) ? 0 : 1);
    end
    drain("t4b_drain");
    chk("t4b_no_trunc", 32'(trunc_seen), 32'd1);
    chk("t4b_owner",    32'(bus.owner),  32'd2);

    // Requester 0 abandons after two of four bytes.
    add_byte(0, 8'h70, 1'b0);
    add_byte(0, 8'h71, 1'b0);
    add_byte(0, 8'h72, 1'b0);
    add_byte(0, 8'h73, 1'b1);
    exp_wr(0, 8'h70, 0);
    exp_wr(0, 8'h71, 1);
    step();
    step();
    step();
    en[0] = 1'b0;
    step();
    chk("t5_abandon_wr",   32'(bus.wr_uart), 32'd0);
    chk("t5_abandon_busy", 32'(bus.busy),    32'd1);
    step();
    chk("t5_released", 32'(bus.busy),  32'd0);
    chk("t5_owner",    32'(bus.owner), 32'd0);
    head[0] = tail[0];
    en[0]   = 1'b1;
    add_byte(0, 8'h74, 1'b1);
    add_byte(1, 8'h81, 1'b1);
    exp_wr(1, 8'h81, 0);
    exp_wr(0, 8'h74, 2);
    drain("t5_drain");

    // Reset during the third byte of a frame from requester 2.
    add_byte(2, 8'h90, 1'b0);
    add_byte(2, 8'h91, 1'b0);
    add_byte(2, 8'h92, 1'b0);
    add_byte(2, 8'h93, 1'b1);
    exp_wr(2, 8'h90, 0);
    exp_wr(2, 8'h91, 1);
    exp_wr(2, 8'h92, 1);
    repeat (4) step();
    chk("t6_pre_wr", 32'(bus.wr_uart), 32'd1);
    #1;
    reset = 1'b1;
    ack_s = '0;
    #1;
    chk("t6_rst_wr",    32'(bus.wr_uart), 32'd0);
    chk("t6_rst_ack",   32'(bus.ack),     32'd0);
    chk("t6_rst_busy",  32'(bus.busy),    32'd0);
    chk("t6_rst_owner", 32'(bus.owner),   32'd3);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_fresh_idle_wr",   32'(bus.wr_uart), 32'd0);
    chk("t6_fresh_idle_busy", 32'(bus.busy),    32'd0);
    exp_wr(2, 8'h92, 0);
    exp_wr(2, 8'h93, 1);
    step();
    chk("t6_regrant", 32'(bus.busy),  32'd1);
    chk("t6_owner",   32'(bus.owner), 32'd2);
    drain("t6_drain");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
